// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the i/d-cache memory port arbiter.
// Contents:
//   arb_state_e  - FSM states (IDLE, SERVE_I, SERVE_D)
//   arb_owner_e  - owner of the shared port (OWN_I, OWN_D)
//   ARB_ADDR_W / ARB_LINE_W - default address and cache-line widths
package cache_arb_pkg;
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_LINE_W = 256;

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_e;
    typedef enum logic       {OWN_I, OWN_D}           arb_owner_e;
endpackage

// File: rtl/cache_arb_pick.sv
// Combinational grant picker for the cache memory arbiter. Holds the
// arbitration policy so the FSM only asks "who goes next".
// Ports:
//   i_pend      - icache has a pending request
//   d_pend      - dcache has a pending request
//   last_owner  - owner of the most recent grant
//   grant_valid - somebody should be granted
//   grant_owner - who gets the grant
// Configuration macro: CACHE_ARB_RR_EN
//   defined   - on a tie, grant the requester opposite last_owner
//   undefined - on a tie, dcache always wins
module cache_arb_pick
    import cache_arb_pkg::*;
(
    input  logic       i_pend,
    input  logic       d_pend,
    input  arb_owner_e last_owner,
    output logic       grant_valid,
    output arb_owner_e grant_owner
);
    logic w_tie_owner_d;

`ifdef CACHE_ARB_RR_EN
    assign w_tie_owner_d = (last_owner == OWN_I);
`else
    // Fixed priority: last_owner is tracked upstream but has no effect here.
    logic w_unused_last_owner;
    assign w_unused_last_owner = (last_owner == OWN_D);
    assign w_tie_owner_d       = 1'b1;
`endif

    always_comb begin
        grant_valid = i_pend | d_pend;
        grant_owner = OWN_I;
        if (d_pend && (!i_pend || w_tie_owner_d))
            grant_owner = OWN_D;
    end
endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single line-granular memory port between the icache and
// the dcache. One owner at a time: the request is latched on the grant edge
// and the shared port is driven only from those latches until m_resp, which
// is routed combinationally to the owner. Every completion is followed by
// one IDLE cycle so the requester can drop its level request.
// Ports:
//   clk, rst (async, active low)
//   i_read/i_addr -> i_rdata/i_resp       icache line read
//   d_read/d_write/d_addr/d_wdata -> d_rdata/d_resp   dcache read/writeback
//   m_read/m_write/m_addr/m_wdata <- m_rdata/m_resp   shared memory port
// Configuration macro: CACHE_ARB_RR_EN (tie policy, see cache_arb_pick).
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_resp
);
    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    arb_owner_e        r_last_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_write;

    logic              w_grant_valid;
    arb_owner_e        w_grant_owner;
    logic              w_grant;

    cache_arb_pick u_pick (
        .i_pend      (i_read),
        .d_pend      (d_read | d_write),
        .last_owner  (r_last_owner),
        .grant_valid (w_grant_valid),
        .grant_owner (w_grant_owner)
    );

    assign w_grant = (r_state == IDLE) && w_grant_valid;

    always_comb begin
        w_state_nxt = r_state;
        m_read      = 1'b0;
        m_write     = 1'b0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        case (r_state)
            IDLE: begin
                // m_resp here is stray and deliberately ignored.
                if (w_grant_valid)
                    w_state_nxt = (w_grant_owner == OWN_D) ? SERVE_D : SERVE_I;
            end
            SERVE_I, SERVE_D: begin
                m_read  = ~r_write;
                m_write =  r_write;
                if (m_resp) begin
                    i_resp      = (r_state == SERVE_I);
                    d_resp      = (r_state == SERVE_D);
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_last_owner <= OWN_I;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_write      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_last_owner <= w_grant_owner;
                if (w_grant_owner == OWN_D) begin
                    r_addr  <= d_addr;
                    r_wdata <= d_wdata;
                    // Read and write together is illegal; the write wins.
                    r_write <= d_write;
                end else begin
                    r_addr  <= i_addr;
                    r_write <= 1'b0;
                end
            end
        end
    end

    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;

    // Read data is broadcast; each cache qualifies it with its own resp.
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;
endmodule
